// File: rtl/prefix_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone prefix carry network.
package prefix_pkg;

  // One (generate, propagate) pair, either per-bit or for a group of bits.
  typedef struct packed {
    logic g;
    logic p;
  } gp_pair;

  // Prefix combine: hi covers the more significant span, lo the span just below it.
  function automatic gp_pair gp_combine(input gp_pair hi, input gp_pair lo);
    gp_pair res;
    res.g = hi.g | (hi.p & lo.g);
    res.p = hi.p & lo.p;
    return res;
  endfunction

  // Number of prefix levels (one per register stage) for a given operand width.
  function automatic int prefix_levels(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/prefix_black_cell.sv
// Combinational Kogge-Stone black cell: res = hi o lo.
module prefix_black_cell
  import prefix_pkg::*;
(
  input  gp_pair hi,
  input  gp_pair lo,
  output gp_pair res
);

  assign res = gp_combine(hi, lo);

endmodule

// File: rtl/prefix_carry_pipe.sv
// Pipelined Kogge-Stone carry network with sum stage. One prefix level per
// register stage, globally stalled valid/ready handshake on both sides.
module prefix_carry_pipe
  import prefix_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LEVELS = prefix_levels(WIDTH);

  // Stage registers, indexed by stage number: index 0 is the capture stage,
  // index LEVELS holds finished carries.
  logic [LEVELS:0]  vld_p;
  logic [LEVELS:0]  cin_p;
  logic [WIDTH-1:0] g_p      [LEVELS+1];
  logic [WIDTH-1:0] p_grp_p  [LEVELS+1];
  logic [WIDTH-1:0] p_orig_p [LEVELS+1];

  // Combinational result of each prefix level, feeding the next stage register.
  logic [WIDTH-1:0] g_nxt [1:LEVELS];
  logic [WIDTH-1:0] p_nxt [1:LEVELS];

  logic adv;

  // A single stall signal freezes the whole pipe, so bubbles keep their slots.
  assign adv      = !vld_p[LEVELS] | out_ready;
  assign in_ready = adv;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int D = 1 << (k - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_cell
        gp_pair hi;
        gp_pair lo;
        gp_pair res;
        assign hi.g = g_p[k-1][i];
        assign hi.p = p_grp_p[k-1][i];
        assign lo.g = g_p[k-1][i-D];
        assign lo.p = p_grp_p[k-1][i-D];
        prefix_black_cell u_cell (
          .hi  (hi),
          .lo  (lo),
          .res (res)
        );
        assign g_nxt[k][i] = res.g;
        assign p_nxt[k][i] = res.p;
      end else begin : g_copy
        // Spans below the level distance are already complete; pass through.
        assign g_nxt[k][i] = g_p[k-1][i];
        assign p_nxt[k][i] = p_grp_p[k-1][i];
      end
    end
  end

  // Stage register update: reset clears everything, otherwise shift on adv.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= LEVELS; k++) begin
        vld_p[k]    <= 1'b0;
        cin_p[k]    <= 1'b0;
        g_p[k]      <= '0;
        p_grp_p[k]  <= '0;
        p_orig_p[k] <= '0;
      end
    end else if (adv) begin
      // p0: fold cin into bit 0 so G[i] becomes the true carry out of bit i
      vld_p[0]    <= in_valid;
      cin_p[0]    <= cin;
      g_p[0]      <= {g_in[WIDTH-1:1], g_in[0] | (p_in[0] & cin)};
      p_grp_p[0]  <= p_in;
      p_orig_p[0] <= p_in;
      // p1..pLEVELS: one prefix level per stage
      for (int k = 1; k <= LEVELS; k++) begin
        vld_p[k]    <= vld_p[k-1];
        cin_p[k]    <= cin_p[k-1];
        g_p[k]      <= g_nxt[k];
        p_grp_p[k]  <= p_nxt[k];
        p_orig_p[k] <= p_orig_p[k-1];
      end
    end
  end

  // Output stage: carries are final, only XOR logic after the last register.
  assign out_valid = vld_p[LEVELS];
  assign sum       = p_orig_p[LEVELS] ^ {g_p[LEVELS][WIDTH-2:0], cin_p[LEVELS]};
  assign cout      = g_p[LEVELS][WIDTH-1];
  assign ovf       = g_p[LEVELS][WIDTH-1] ^ g_p[LEVELS][WIDTH-2];

  // Group propagate of the final stage has no consumer.
  logic unused_grp_p;
  assign unused_grp_p = ^p_grp_p[LEVELS];

endmodule

// File: tb/tb_prefix_carry_pipe.sv
// Scoreboard bench for prefix_carry_pipe (WIDTH=16).
module tb_prefix_carry_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] g_in;
  logic [W-1:0] p_in;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  prefix_carry_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .g_in      (g_in),
    .p_in      (p_in),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  // Move to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present one x,y,cin operand and wait (bounded) until it is accepted.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                      input bit lat);
    logic [W:0] full;
    exp_t e;
    bit   ok;
    int   n;
    in_valid = 1'b1;
    g_in     = x & y;
    p_in     = x ^ y;
    cin      = ci;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      chk("send_timeout", 32'd0, 32'd1);
    end else begin
      full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
      e.acc  = cyc;
      e.lat  = lat;
      sb.push_back(e);
    end
    #1;
    in_valid = 1'b0;
  endtask

  // Output monitor: compares each transfer in order and checks held outputs.
  logic         held_v = 1'b0;
  logic [W-1:0] held_sum;
  logic         held_cout;
  logic         held_ovf;

  always @(negedge clk) begin
    exp_t e;
    if (held_v) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_sum", {16'd0, sum}, {16'd0, held_sum});
      chk("hold_cout_ovf", {30'd0, cout, ovf}, {30'd0, held_cout, held_ovf});
    end
    held_v    = out_valid && !out_ready && !rst;
    held_sum  = sum;
    held_cout = cout;
    held_ovf  = ovf;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("stale_output", {16'd0, sum}, 32'hDEAD_BEEF);
      end else begin
        e = sb.pop_front();
        chk("sum", {16'd0, sum}, {16'd0, e.sum});
        chk("cout", {31'd0, cout}, {31'd0, e.cout});
        chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        if (e.lat) chk("latency", cyc - e.acc, 32'd4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] pat;
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    bit   stall_ok;
    rst       = 1'b1;
    in_valid  = 1'b0;
    g_in      = '0;
    p_in      = '0;
    cin       = 1'b0;
    out_ready = 1'b1;

    // Reset state
    step();
    step();
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    step();

    // Directed operands with latency checks
    send(16'h1234, 16'h0001, 1'b0, 1'b1);
    repeat (6) step();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    repeat (6) step();
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    repeat (6) step();
    send(16'h0000, 16'hFFFF, 1'b1, 1'b1);
    repeat (6) step();
    send(16'h8000, 16'h8000, 1'b0, 1'b1);
    repeat (6) step();

    // 8 back-to-back random operands, consumer stalls output cycles 3-6
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          rx = W'($urandom);
          ry = W'($urandom);
          send(rx, ry, 1'($urandom), 1'b0);
        end
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("stall_first_out", {31'd0, out_valid}, 32'd1);
        step();
        for (int c = 3; c <= 6; c++) begin
          out_ready = 1'b0;
          @(negedge clk);
          chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
          step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("unstall_in_ready", {31'd0, in_ready}, 32'd1);
      end
    join
    repeat (20) step();
    chk("stall_drained", sb.size(), 32'd0);

    // Reset with three operations in flight
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h4444, 1'b1, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    g_in     = 16'hAAAA;
    p_in     = 16'h5555;
    cin      = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sum", {16'd0, sum}, 32'd0);
    chk("mid_rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    stall_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) stall_ok = 1'b0;
    end
    chk("no_stale_after_rst", {31'd0, stall_ok}, 32'd1);
    step();
    send(16'h00FF, 16'h0F0F, 1'b1, 1'b1);
    repeat (6) step();

    // Bubbles: in_valid 1,0,1,0 gives out_valid 1,0,1,0 four cycles later
    send(16'hABCD, 16'h1357, 1'b0, 1'b1);
    step();
    send(16'h8001, 16'h8001, 1'b1, 1'b1);
    step();
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      pat[j] = out_valid;
    end
    chk("bubble_pattern", {26'd0, pat}, 32'h0000_000A);
    repeat (4) step();

    chk("final_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
